// File: rtl/dsp_add_pkg.sv
// Shared helpers and pipeline control type for the compensating N-operand adder.
package dsp_add_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit res_width_ok(input int op_width, input int n_ops, input int res_width);
        return res_width >= op_width + clog2(n_ops) + 1;
    endfunction

    // Per-beat control that rides alongside the data through every stage.
    typedef struct packed {
        logic valid;
        logic last;
        logic mode;
    } stage_ctl_t;

endpackage

// File: rtl/dsp_add_pair_level.sv
// One registered level of the adder tree: sums adjacent pairs, holds when en is low.
module dsp_add_pair_level
    import dsp_add_pkg::*;
#(
    parameter int IN_CNT     = 2,
    parameter int W          = 48,
    parameter int USER_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic [IN_CNT-1:0][W-1:0]     in_sum,
    input  stage_ctl_t                   in_ctl,
    input  logic [USER_WIDTH-1:0]        in_user,
    output logic [IN_CNT/2-1:0][W-1:0]   out_sum,
    output stage_ctl_t                   out_ctl,
    output logic [USER_WIDTH-1:0]        out_user
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) out_ctl <= '0;
        else if (en)       out_ctl <= in_ctl;
    end

    // Data carries no reset; only the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < IN_CNT / 2; i++)
                out_sum[i] <= in_sum[2*i] + in_sum[2*i+1];
            out_user <= in_user;
        end
    end

endmodule

// File: rtl/dsp_addn_cin_acc.sv
// Pipelined N-operand signed adder with masked carry compensation, flow control
// and an optional multi-beat frame accumulator with overflow flag.
module dsp_addn_cin_acc
    import dsp_add_pkg::*;
#(
    parameter int               N_OPS      = 8,
    parameter int               OP_WIDTH   = 18,
    parameter int               RES_WIDTH  = 48,
    parameter logic [N_OPS-1:0] CIN_MASK   = N_OPS'(8'b1100_1100),
    parameter int               USER_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      dsp_reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_OPS*OP_WIDTH-1:0] ops,
    input  logic [N_OPS-1:0]          cin,
    input  logic                      acc_mode,
    input  logic                      in_last,
    input  logic [USER_WIDTH-1:0]     in_user,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_WIDTH-1:0]      result,
    output logic [USER_WIDTH-1:0]     out_user,
    output logic                      out_ovf
);

    localparam int L = clog2(N_OPS);
    localparam int P = 1 << L;

    if (!res_width_ok(OP_WIDTH, N_OPS, RES_WIDTH) || N_OPS < 2 || N_OPS > 32) begin : g_param_check
        $error("dsp_addn_cin_acc: N_OPS out of range or RES_WIDTH too narrow");
    end

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = aresetn && !dsp_reset && adv;

    // Stage 0: sign-extend, fold in the masked carry, pad to a power of two.
    logic [P-1:0][RES_WIDTH-1:0] s0_next, s0_sum;
    stage_ctl_t                  s0_ctl;
    logic [USER_WIDTH-1:0]       s0_user;

    always_comb begin
        s0_next = '0;
        for (int i = 0; i < N_OPS; i++)
            s0_next[i] = RES_WIDTH'($signed(ops[i*OP_WIDTH +: OP_WIDTH]))
                       + RES_WIDTH'(cin[i] & CIN_MASK[i]);
    end

    always_ff @(posedge clk) begin
        if (!aresetn || dsp_reset) s0_ctl <= '0;
        else if (adv)              s0_ctl <= '{valid: in_valid, last: in_last, mode: acc_mode};
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s0_sum  <= s0_next;
            s0_user <= in_user;
        end
    end

    // Tree levels packed back to back: level k+1 output starts at P - (P >> k).
    logic [P-2:0][RES_WIDTH-1:0]  lvl_sum;
    stage_ctl_t [L:1]             lvl_ctl;
    logic [L:1][USER_WIDTH-1:0]   lvl_user;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int CNT = P >> k;
        if (k == 0) begin : g_first
            dsp_add_pair_level #(.IN_CNT(CNT), .W(RES_WIDTH), .USER_WIDTH(USER_WIDTH)) u_lvl (
                .clk      (clk),
                .rst_n    (aresetn),
                .clr      (dsp_reset),
                .en       (adv),
                .in_sum   (s0_sum),
                .in_ctl   (s0_ctl),
                .in_user  (s0_user),
                .out_sum  (lvl_sum[P-CNT +: CNT/2]),
                .out_ctl  (lvl_ctl[k+1]),
                .out_user (lvl_user[k+1])
            );
        end else begin : g_next
            dsp_add_pair_level #(.IN_CNT(CNT), .W(RES_WIDTH), .USER_WIDTH(USER_WIDTH)) u_lvl (
                .clk      (clk),
                .rst_n    (aresetn),
                .clr      (dsp_reset),
                .en       (adv),
                .in_sum   (lvl_sum[P-2*CNT +: CNT]),
                .in_ctl   (lvl_ctl[k]),
                .in_user  (lvl_user[k]),
                .out_sum  (lvl_sum[P-CNT +: CNT/2]),
                .out_ctl  (lvl_ctl[k+1]),
                .out_user (lvl_user[k+1])
            );
        end
    end

    logic [RES_WIDTH-1:0]  tree, acc, acc_sum;
    logic [USER_WIDTH-1:0] tuser;
    stage_ctl_t            tctl;
    logic                  in_frame, acc_ovf, add_ovf, frame_ovf;

    assign tree  = lvl_sum[P-2];
    assign tctl  = lvl_ctl[L];
    assign tuser = lvl_user[L];

    // First beat of a frame loads, so it can never overflow.
    assign acc_sum   = in_frame ? acc + tree : tree;
    assign add_ovf   = in_frame && (acc[RES_WIDTH-1] == tree[RES_WIDTH-1])
                                && (acc_sum[RES_WIDTH-1] != acc[RES_WIDTH-1]);
    assign frame_ovf = acc_ovf || add_ovf;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_user  <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            in_frame  <= 1'b0;
        end else if (dsp_reset) begin
            out_valid <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            in_frame  <= 1'b0;
        end else if (adv) begin
            out_valid <= tctl.valid && (!tctl.mode || tctl.last);
            if (tctl.valid && !tctl.mode) begin
                result   <= tree;
                out_user <= tuser;
                out_ovf  <= 1'b0;
            end else if (tctl.valid && tctl.last) begin
                result   <= acc_sum;
                out_user <= tuser;
                out_ovf  <= frame_ovf;
                acc      <= '0;
                acc_ovf  <= 1'b0;
                in_frame <= 1'b0;
            end else if (tctl.valid) begin
                acc      <= acc_sum;
                acc_ovf  <= frame_ovf;
                in_frame <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_addn_cin_acc.sv
// Scoreboard bench: a plain-arithmetic frame model pushes expectations at accept time,
// a negedge monitor pops and compares whenever a DUT presents a result.
module tb_dsp_addn_cin_acc;

    localparam int         N0    = 8;
    localparam int         N1    = 5;
    localparam int         OPW   = 18;
    localparam int         RW0   = 48;
    localparam int         RW1   = 22;
    localparam int         UW    = 8;
    localparam logic [7:0] MASK0 = 8'b1100_1100;
    localparam logic [4:0] MASK1 = 5'b00101;
    localparam int         LAT0  = 5;

    typedef int ops_t[8];
    typedef struct {
        longint     res;
        logic [7:0] user;
        bit         ovf;
        int         acc_cyc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn, dsp_reset;
    logic in_valid0, in_ready0, acc_mode0, in_last0, out_valid0, out_ready0, out_ovf0;
    logic [N0*OPW-1:0] ops0;
    logic [N0-1:0]     cin0;
    logic [UW-1:0]     in_user0, out_user0;
    logic [RW0-1:0]    result0;
    logic in_valid1, in_ready1, acc_mode1, in_last1, out_valid1, out_ready1, out_ovf1;
    logic [N1*OPW-1:0] ops1;
    logic [N1-1:0]     cin1;
    logic [UW-1:0]     in_user1, out_user1;
    logic [RW1-1:0]    result1;

    dsp_addn_cin_acc u_dut0 (
        .clk(clk), .aresetn(aresetn), .dsp_reset(dsp_reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .ops(ops0), .cin(cin0),
        .acc_mode(acc_mode0), .in_last(in_last0), .in_user(in_user0),
        .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
        .out_user(out_user0), .out_ovf(out_ovf0)
    );

    dsp_addn_cin_acc #(.N_OPS(N1), .OP_WIDTH(OPW), .RES_WIDTH(RW1), .CIN_MASK(MASK1), .USER_WIDTH(UW)) u_dut1 (
        .clk(clk), .aresetn(aresetn), .dsp_reset(dsp_reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .ops(ops1), .cin(cin1),
        .acc_mode(acc_mode1), .in_last(in_last1), .in_user(in_user1),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .out_user(out_user1), .out_ovf(out_ovf1)
    );

    exp_t   q0[$], q1[$];
    int     n_chk = 0, n_pass = 0;
    int     cyc = 0;
    int     stall = 0;
    bit     mon_on = 0;
    longint acc_m[2];
    bit     frame_m[2], ovf_m[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m = v & ((longint'(1) << w) - 1);
        if (((m >> (w - 1)) & 1) != 0) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic ops_t fill(input int v);
        ops_t o;
        for (int i = 0; i < 8; i++) o[i] = v;
        return o;
    endfunction

    // Reference: plain integer sum of the beat, then frame accumulation with wrap detection.
    function automatic void model(input int sel, input ops_t opv, input logic [7:0] cv,
                                  input bit mode, input bit last, input logic [7:0] usr, input int lat);
        int         n = sel ? N1 : N0;
        int         w = sel ? RW1 : RW0;
        logic [7:0] m = sel ? 8'(MASK1) : MASK0;
        longint     s = 0;
        longint     exact;
        bit         o;
        exp_t       e;
        for (int i = 0; i < n; i++) s += longint'(opv[i]) + ((cv[i] && m[i]) ? 1 : 0);
        s = wrap(s, w);
        e.user = usr; e.acc_cyc = cyc; e.lat = lat;
        if (!mode) begin
            e.res = s; e.ovf = 0;
            if (sel) q1.push_back(e); else q0.push_back(e);
        end else begin
            exact = frame_m[sel] ? acc_m[sel] + s : s;
            o = (frame_m[sel] && ovf_m[sel]) || (exact != wrap(exact, w));
            if (last) begin
                e.res = wrap(exact, w); e.ovf = o;
                if (sel) q1.push_back(e); else q0.push_back(e);
                frame_m[sel] = 0; ovf_m[sel] = 0; acc_m[sel] = 0;
            end else begin
                acc_m[sel] = wrap(exact, w); frame_m[sel] = 1; ovf_m[sel] = o;
            end
        end
    endfunction

    task automatic mon(input int sel, input logic v, input logic rdy, input longint r,
                       input logic [7:0] u, input logic o);
        exp_t  e;
        string tag = sel ? "dut1" : "dut0";
        if (!v) return;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            n_chk++;
            $display("FAIL %s unexpected output: got result %0d, expected no output", tag, r);
            return;
        end
        e = sel ? q1[0] : q0[0];
        chk({tag, " result"}, r, e.res);
        chk({tag, " out_user"}, longint'(u), longint'(e.user));
        chk({tag, " out_ovf"}, longint'(o), longint'(e.ovf));
        if (e.lat > 0) chk({tag, " latency"}, longint'(cyc - e.acc_cyc), longint'(e.lat));
        if (rdy) begin
            if (sel) void'(q1.pop_front()); else void'(q0.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, out_valid0, out_ready0, longint'($signed(result0)), out_user0, out_ovf0);
            mon(1, out_valid1, out_ready1, longint'($signed(result1)), out_user1, out_ovf1);
        end
    end

    initial begin
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready0 = (stall == 0);
            if (stall > 0) stall--;
        end
    end

    task automatic send(input int sel, input ops_t opv, input logic [7:0] cv, input bit mode,
                        input bit last, input logic [7:0] usr, input int lat);
        bit done = 0;
        int guard = 0;
        if (sel == 0) begin
            for (int i = 0; i < N0; i++) ops0[i*OPW +: OPW] = opv[i][OPW-1:0];
            cin0 = cv; acc_mode0 = mode; in_last0 = last; in_user0 = usr; in_valid0 = 1'b1;
        end else begin
            for (int i = 0; i < N1; i++) ops1[i*OPW +: OPW] = opv[i][OPW-1:0];
            cin1 = cv[N1-1:0]; acc_mode1 = mode; in_last1 = last; in_user1 = usr; in_valid1 = 1'b1;
        end
        while (!done) begin
            @(negedge clk);
            if ((sel == 0 && in_ready0) || (sel == 1 && in_ready1)) begin
                model(sel, opv, cv, mode, last, usr, lat);
                done = 1;
            end else if (++guard > 50) begin
                n_chk++;
                $display("FAIL dut%0d accept timeout: in_ready stayed 0, expected 1", sel);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 300) begin
            @(posedge clk);
            g++;
        end
        chk({name, " pending outputs"}, longint'(q0.size() + q1.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        ops_t o;
        aresetn = 1'b0; dsp_reset = 1'b0;
        in_valid0 = 0; ops0 = '0; cin0 = '0; acc_mode0 = 0; in_last0 = 0; in_user0 = '0;
        in_valid1 = 0; ops1 = '0; cin1 = '0; acc_mode1 = 0; in_last1 = 0; in_user1 = '0;
        frame_m = '{0, 0}; ovf_m = '{0, 0}; acc_m = '{0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid0, 0);
        chk("reset in_ready", in_ready0, 0);
        chk("reset result", longint'(result0), 0);
        chk("reset out_user", longint'(out_user0), 0);
        chk("reset out_ovf", out_ovf0, 0);
        chk("reset dut1 out_valid", out_valid1, 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", in_ready0, 1);
        mon_on = 1;
        @(posedge clk); #1;

        // Extremes and carry masking
        send(0, fill(131071), 8'hFF, 0, 0, 8'h11, LAT0);
        send(0, fill(-131072), 8'h00, 0, 0, 8'h22, 0);
        send(0, fill(0), 8'hFF, 0, 0, 8'h33, 0);

        // Three-beat frame of 10s, then a single-beat frame
        o = fill(0); o[0] = 6;
        send(0, o, 8'hFF, 1, 0, 8'h40, 0);
        send(0, o, 8'hFF, 1, 0, 8'h41, 0);
        send(0, o, 8'hFF, 1, 1, 8'h42, 0);
        o[0] = 7;
        send(0, o, 8'h00, 1, 1, 8'h43, 0);

        // Random stream with a downstream stall in the middle
        for (int i = 0; i < 20; i++) begin
            ops_t r;
            for (int j = 0; j < 8; j++) r[j] = int'($urandom_range(262143)) - 131072;
            if (i == 8) stall = 3;
            send(0, r, 8'($urandom), 0, 0, 8'(i), 0);
        end

        // Random accumulate frames of 1..4 beats
        for (int f = 0; f < 3; f++) begin
            int len = int'($urandom_range(4, 1));
            for (int b = 0; b < len; b++) begin
                ops_t r;
                for (int j = 0; j < 8; j++) r[j] = int'($urandom_range(262143)) - 131072;
                send(0, r, 8'($urandom), 1, b == len - 1, 8'(8'h80 + f), 0);
            end
        end
        drain("stream");

        // Mid-frame datapath clear discards the partial frame
        o = fill(0); o[0] = 3; o[1] = 2;
        send(0, o, 8'h00, 1, 0, 8'h60, 0);
        send(0, o, 8'h00, 1, 0, 8'h61, 0);
        dsp_reset = 1'b1;
        @(negedge clk);
        chk("in_ready during dsp_reset", in_ready0, 0);
        @(posedge clk); #1;
        dsp_reset = 1'b0;
        frame_m = '{0, 0}; ovf_m = '{0, 0}; acc_m = '{0, 0};
        @(negedge clk);
        chk("out_valid after dsp_reset", out_valid0, 0);
        @(posedge clk); #1;
        send(0, o, 8'h00, 1, 0, 8'h62, 0);
        send(0, o, 8'h00, 1, 1, 8'h63, 0);

        // Narrow instance: accumulate max sums until the accumulator wraps
        o = fill(131071);
        for (int b = 0; b < 4; b++) send(1, o, 8'hFF, 1, b == 3, 8'h50, 0);
        o = fill(0); o[0] = 7;
        send(1, o, 8'h00, 1, 1, 8'h51, 0);

        drain("final");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
